wb_result_checker: RTL and testbench

Parametrised, synthesizable self-checking monitor for CPU instruction tests. It snoops the pipeline's register-file writeback port and keeps a shadow register file. When the program reaches a configured end PC, or a cycle budget expires, it compares up to NUM_CHECKS expected register values and streams one result beat per check over a valid/ready port. It sits beside `cpu` in instruction-test benches and FPGA bring-up builds, replacing hierarchical register peeks with a reusable checker.

---
 rtl/wb_result_checker_pkg.sv | 21 ++
 rtl/wb_result_checker_shadow_regfile.sv | 36 +++
 rtl/wb_result_checker.sv | 192 +++++++++++++++++++
 tb/tb_wb_result_checker.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_result_checker_pkg.sv
// Shared types for the writeback result checker: FSM states and the
// expected-value table entry (sized for the widest supported configuration).
package checker_pkg;

   localparam int unsigned CHK_MAX_XLEN = 64;
   localparam int unsigned CHK_MAX_RW   = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CHECK,
      DONE
   } chk_state_t;

   typedef struct packed {
      logic                    valid;
      logic [CHK_MAX_RW-1:0]   rd;
      logic [CHK_MAX_XLEN-1:0] value;
   } chk_entry_t;

endpackage

// File: rtl/wb_result_checker_shadow_regfile.sv
// Shadow copy of the architectural register file: one synchronous write port
// with an x0 guard, a synchronous clear-all, and one asynchronous read port.
module shadow_regfile #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned RW       = 5
) (
   input  logic            clk,
   input  logic            i_clear,
   input  logic            i_wr_en,
   input  logic [RW-1:0]   i_wr_idx,
   input  logic [XLEN-1:0] i_wr_data,
   input  logic [RW-1:0]   i_rd_idx,
   output logic [XLEN-1:0] o_rd_data
);

   logic [XLEN-1:0] r_mem [NUM_REGS];

   always_ff @(posedge clk) begin
      if (i_clear) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_wr_en && (i_wr_idx != '0) && (32'(i_wr_idx) < NUM_REGS)) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   always_comb begin
      o_rd_data = '0;
      if (32'(i_rd_idx) < NUM_REGS) begin
         o_rd_data = r_mem[i_rd_idx];
      end
   end

endmodule

// File: rtl/wb_result_checker.sv
// Writeback-snooping result checker: shadows the register file during a run,
// then streams one compare result per valid table entry over valid/ready.
module wb_result_checker
   import checker_pkg::*;
#(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned NUM_REGS   = 32,
   parameter int unsigned NUM_CHECKS = 8,
   parameter int unsigned TIMEOUT    = 1024,
   localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
   localparam int unsigned CW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
   localparam int unsigned TW = $clog2(TIMEOUT + 1)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            cfg_wr_en,
   input  logic [CW-1:0]   cfg_idx,
   input  logic [RW-1:0]   cfg_rd,
   input  logic [XLEN-1:0] cfg_value,
   input  logic [XLEN-1:0] cfg_end_pc,
   input  logic            start,
   input  logic            wb_en,
   input  logic [RW-1:0]   wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic [XLEN-1:0] pc,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [CW-1:0]   res_idx,
   output logic            res_ok,
   output logic [XLEN-1:0] res_got,
   output logic            done,
   output logic            pass,
   output logic            timed_out,
   output logic [CW:0]     fail_count,
   output logic [TW-1:0]   cycle_count
);

   chk_state_t      r_state;
   chk_state_t      w_state_nxt;
   chk_entry_t      r_table [NUM_CHECKS];
   logic [XLEN-1:0] r_end_pc;
   logic [TW-1:0]   r_cycle;
   logic [CW:0]     r_fail;
   logic            r_timed_out;
   logic            r_res_valid;
   logic [CW-1:0]   r_res_idx;
   logic            r_res_ok;
   logic [XLEN-1:0] r_res_got;

   logic                    w_start_acc;
   logic                    w_pc_hit;
   logic                    w_timeout_hit;
   logic                    w_run_end;
   logic                    w_handshake;
   logic [CW:0]             w_search_base;
   logic                    w_found;
   logic [CW-1:0]           w_found_idx;
   logic [CHK_MAX_RW-1:0]   w_sel_rd_full;
   logic [CHK_MAX_XLEN-1:0] w_sel_value;
   logic                    w_sel_in_range;
   logic [RW-1:0]           w_sel_rd;
   logic [XLEN-1:0]         w_shadow_rd_data;
   logic                    w_fwd;
   logic [XLEN-1:0]         w_beat_got;
   logic                    w_beat_ok;

   assign w_start_acc   = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_pc_hit      = (pc == r_end_pc);
   assign w_timeout_hit = (r_cycle == TW'(TIMEOUT - 1));
   assign w_run_end     = (r_state == RUN) && (w_pc_hit || w_timeout_hit);
   assign w_handshake   = (r_state == CHECK) && r_res_valid && res_ready;

   // Search starts at entry 0 when leaving RUN, otherwise just past the beat in flight.
   assign w_search_base = (r_state == CHECK) ? ({1'b0, r_res_idx} + (CW+1)'(1)) : '0;

   always_comb begin
      w_found     = 1'b0;
      w_found_idx = '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
         if (!w_found && r_table[i].valid && ((CW+1)'(i) >= w_search_base)) begin
            w_found     = 1'b1;
            w_found_idx = CW'(i);
         end
      end
   end

   assign w_sel_rd_full  = r_table[w_found_idx].rd;
   assign w_sel_value    = r_table[w_found_idx].value;
   assign w_sel_in_range = (w_sel_rd_full < CHK_MAX_RW'(NUM_REGS));
   assign w_sel_rd       = w_sel_rd_full[RW-1:0];

   // The first beat is built in the end-PC cycle, so that cycle's writeback is forwarded.
   assign w_fwd      = (r_state == RUN) && wb_en && (wb_rd != '0) && (wb_rd == w_sel_rd);
   assign w_beat_got = !w_sel_in_range ? '0 : (w_fwd ? wb_data : w_shadow_rd_data);
   assign w_beat_ok  = (CHK_MAX_XLEN'(w_beat_got) == w_sel_value);

   shadow_regfile #(
      .XLEN     (XLEN),
      .NUM_REGS (NUM_REGS),
      .RW       (RW)
   ) u_shadow (
      .clk       (clk),
      .i_clear   (reset || w_start_acc),
      .i_wr_en   ((r_state == RUN) && wb_en),
      .i_wr_idx  (wb_rd),
      .i_wr_data (wb_data),
      .i_rd_idx  (w_sel_rd),
      .o_rd_data (w_shadow_rd_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = RUN;
         RUN:     if (w_pc_hit || w_timeout_hit) w_state_nxt = CHECK;
         CHECK:   if (!r_res_valid || (w_handshake && !w_found)) w_state_nxt = DONE;
         DONE:    if (start) w_state_nxt = RUN;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      res_valid   = r_res_valid;
      res_idx     = r_res_idx;
      res_ok      = r_res_ok;
      res_got     = r_res_got;
      done        = (r_state == DONE);
      pass        = (r_state == DONE) && (r_fail == '0) && !r_timed_out;
      timed_out   = r_timed_out;
      fail_count  = r_fail;
      cycle_count = r_cycle;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
            r_table[i] <= '0;
         end
      end else if ((r_state == IDLE) && cfg_wr_en && ({1'b0, cfg_idx} < (CW+1)'(NUM_CHECKS))) begin
         r_table[cfg_idx].valid <= 1'b1;
         r_table[cfg_idx].rd    <= CHK_MAX_RW'(cfg_rd);
         r_table[cfg_idx].value <= CHK_MAX_XLEN'(cfg_value);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_end_pc    <= '0;
         r_cycle     <= '0;
         r_fail      <= '0;
         r_timed_out <= 1'b0;
      end else if (w_start_acc) begin
         r_end_pc    <= cfg_end_pc;
         r_cycle     <= '0;
         r_fail      <= '0;
         r_timed_out <= 1'b0;
      end else begin
         if ((r_state == RUN) && (r_cycle != TW'(TIMEOUT))) begin
            r_cycle <= r_cycle + TW'(1);
         end
         if ((r_state == RUN) && w_timeout_hit && !w_pc_hit) begin
            r_timed_out <= 1'b1;
         end
         if (w_handshake && !r_res_ok) begin
            r_fail <= r_fail + (CW+1)'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_res_valid <= 1'b0;
         r_res_idx   <= '0;
         r_res_ok    <= 1'b0;
         r_res_got   <= '0;
      end else if (w_run_end || w_handshake) begin
         r_res_valid <= w_found;
         r_res_idx   <= w_found_idx;
         r_res_ok    <= w_found && w_beat_ok;
         r_res_got   <= w_found ? w_beat_got : '0;
      end
   end

endmodule

// File: tb/tb_wb_result_checker.sv
// Randomised scoreboard bench for wb_result_checker: a per-run reference model
// predicts the beat stream and the final status; a monitor checks every beat.
module tb_wb_result_checker;

   localparam int XLEN = 32;
   localparam int NR   = 32;
   localparam int NC   = 8;
   localparam int TO   = 16;

   logic        clk;
   logic        reset;
   logic        cfg_wr_en;
   logic [2:0]  cfg_idx;
   logic [4:0]  cfg_rd;
   logic [31:0] cfg_value;
   logic [31:0] cfg_end_pc;
   logic        start;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] pc;
   logic        res_valid;
   logic        res_ready;
   logic [2:0]  res_idx;
   logic        res_ok;
   logic [31:0] res_got;
   logic        done;
   logic        pass;
   logic        timed_out;
   logic [3:0]  fail_count;
   logic [4:0]  cycle_count;

   wb_result_checker #(
      .XLEN       (XLEN),
      .NUM_REGS   (NR),
      .NUM_CHECKS (NC),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_wr_en   (cfg_wr_en),
      .cfg_idx     (cfg_idx),
      .cfg_rd      (cfg_rd),
      .cfg_value   (cfg_value),
      .cfg_end_pc  (cfg_end_pc),
      .start       (start),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .pc          (pc),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_idx     (res_idx),
      .res_ok      (res_ok),
      .res_got     (res_got),
      .done        (done),
      .pass        (pass),
      .timed_out   (timed_out),
      .fail_count  (fail_count),
      .cycle_count (cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      int unsigned idx;
      bit          ok;
      logic [31:0] got;
   } beat_t;
   beat_t sb[$];

   // Program trace: one entry per RUN cycle.
   logic [31:0] p_pc   [16];
   bit          p_we   [16];
   logic [4:0]  p_rd   [16];
   logic [31:0] p_data [16];
   bit          p_start[16];
   bit          p_cfg  [16];

   // Reference model state.
   bit          m_valid[NC];
   logic [4:0]  m_rd   [NC];
   logic [31:0] m_val  [NC];
   logic [31:0] m_sh   [NR];
   int          m_L;
   bit          m_timed;
   int          m_fail;
   bit          m_idle;

   int rdy_mode  = 0;
   int stall_cnt = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (!reset && res_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_beat: got idx %0d expected no beat", res_idx);
         end else begin
            e = sb[0];
            chk("beat_idx", 64'(res_idx), 64'(e.idx));
            chk("beat_ok", 64'(res_ok), 64'(e.ok));
            chk("beat_got", 64'(res_got), 64'(e.got));
            if (res_ready) void'(sb.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: res_ready = 1'b1;
         1: res_ready = 1'($urandom_range(0, 1));
         2: begin
            if (res_valid && stall_cnt < 5) stall_cnt++;
            res_ready = (stall_cnt >= 5);
         end
         default: res_ready = 1'b0;
      endcase
   end

   // Architectural effect of a run: which writes land and why/when the run ends.
   task automatic model_run(input logic [31:0] epc);
      for (int r = 0; r < NR; r++) m_sh[r] = '0;
      m_L     = TO;
      m_timed = 1'b1;
      for (int k = 0; k < TO; k++) begin
         if (p_we[k] && p_rd[k] != 5'd0) m_sh[p_rd[k]] = p_data[k];
         if (p_pc[k] == epc) begin
            m_L     = k + 1;
            m_timed = 1'b0;
            break;
         end
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      wb_en     = 1'b0;
      sb.delete();
      tick();
      tick();
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_res_idx", 64'(res_idx), 0);
      chk("rst_res_ok", 64'(res_ok), 0);
      chk("rst_res_got", 64'(res_got), 0);
      chk("rst_done", 64'(done), 0);
      chk("rst_pass", 64'(pass), 0);
      chk("rst_timed_out", 64'(timed_out), 0);
      chk("rst_fail_count", 64'(fail_count), 0);
      chk("rst_cycle_count", 64'(cycle_count), 0);
      reset = 1'b0;
      for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
      m_idle = 1'b1;
   endtask

   task automatic cfg_write(input int idx, input int rd, input logic [31:0] val);
      cfg_idx   = 3'(idx);
      cfg_rd    = 5'(rd);
      cfg_value = val;
      cfg_wr_en = 1'b1;
      tick();
      cfg_wr_en = 1'b0;
      if (m_idle) begin
         m_valid[idx] = 1'b1;
         m_rd[idx]    = 5'(rd);
         m_val[idx]   = val;
      end
   endtask

   task automatic launch(input logic [31:0] epc);
      model_run(epc);
      m_fail = 0;
      for (int i = 0; i < NC; i++) begin
         if (m_valid[i]) begin
            beat_t b;
            b.idx = i;
            b.got = m_sh[m_rd[i]];
            b.ok  = (b.got == m_val[i]);
            if (!b.ok) m_fail++;
            sb.push_back(b);
         end
      end
      m_idle     = 1'b0;
      cfg_end_pc = epc;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      cfg_end_pc = 32'hFFFF_FFFC;
      for (int k = 0; k < TO; k++) begin
         pc        = p_pc[k];
         wb_en     = p_we[k];
         wb_rd     = p_rd[k];
         wb_data   = p_data[k];
         start     = p_start[k];
         cfg_wr_en = p_cfg[k];
         cfg_idx   = 3'($urandom);
         cfg_rd    = 5'($urandom);
         cfg_value = $urandom;
         tick();
      end
      wb_en     = 1'b0;
      start     = 1'b0;
      cfg_wr_en = 1'b0;
      pc        = 32'h0000_1000;
   endtask

   task automatic finish_run();
      int n = 0;
      while (!done && n < 100) begin
         tick();
         n++;
      end
      chk("done", 64'(done), 1);
      chk("beats_pending", 64'(sb.size()), 0);
      chk("fail_count", 64'(fail_count), 64'(m_fail));
      chk("timed_out", 64'(timed_out), 64'(m_timed));
      chk("cycle_count", 64'(cycle_count), 64'(m_L));
      chk("pass", 64'(pass), 64'((m_fail == 0) && !m_timed));
      sb.delete();
   endtask

   task automatic prog_clear();
      for (int k = 0; k < TO; k++) begin
         p_pc[k]    = 32'(4 * k);
         p_we[k]    = 1'b0;
         p_rd[k]    = '0;
         p_data[k]  = '0;
         p_start[k] = 1'b0;
         p_cfg[k]   = 1'b0;
      end
   endtask

   task automatic prog_upper_imm();
      prog_clear();
      p_we[1] = 1'b1; p_rd[1] = 5'd10; p_data[1] = 32'hABCD_E000;
      p_we[2] = 1'b1; p_rd[2] = 5'd11; p_data[2] = 32'h1111_1008;
      p_we[8] = 1'b1; p_rd[8] = 5'd12; p_data[8] = 32'h0000_0055;
      p_we[9] = 1'b1; p_rd[9] = 5'd10; p_data[9] = 32'h0000_0000;
      p_start[3] = 1'b1;
      p_cfg[4]   = 1'b1;
   endtask

   task automatic prog_random(input logic [31:0] epc);
      prog_clear();
      for (int k = 0; k < TO; k++) begin
         p_pc[k]   = 32'(4 * $urandom_range(0, 15));
         p_we[k]   = 1'($urandom_range(0, 1));
         p_rd[k]   = 5'($urandom_range(0, 7));
         p_data[k] = $urandom;
      end
      model_run(epc);
      if ($urandom_range(0, 1) == 1) p_start[$urandom_range(0, m_L - 1)] = 1'b1;
      if ($urandom_range(0, 1) == 1) p_cfg[$urandom_range(0, m_L - 1)] = 1'b1;
   endtask

   initial begin
      logic [31:0] epc;
      int          rd;
      reset      = 1'b1;
      cfg_wr_en  = 1'b0;
      cfg_idx    = '0;
      cfg_rd     = '0;
      cfg_value  = '0;
      cfg_end_pc = '0;
      start      = 1'b0;
      wb_en      = 1'b0;
      wb_rd      = '0;
      wb_data    = '0;
      pc         = '0;
      res_ready  = 1'b0;

      // Upper-immediate program, all expectations met, end-cycle writeback captured.
      do_reset();
      rdy_mode = 0;
      cfg_write(0, 10, 32'hABCD_E000);
      cfg_write(1, 11, 32'h1111_1008);
      cfg_write(2, 12, 32'h0000_0055);
      prog_upper_imm();
      launch(32'h20);
      finish_run();
      chk("t1_pass_const", 64'(pass), 1);

      // Table persists; writes outside IDLE are dropped; rerun straight from DONE.
      cfg_write(3, 12, 32'h0000_0000);
      launch(32'h20);
      finish_run();

      // Wrong x11 expectation.
      do_reset();
      cfg_write(0, 10, 32'hABCD_E000);
      cfg_write(1, 11, 32'h1111_1000);
      launch(32'h20);
      finish_run();
      chk("t2_fail_const", 64'(fail_count), 1);

      // End PC never reached: timeout.
      do_reset();
      cfg_write(0, 10, 32'hABCD_E000);
      launch(32'hDEAD_0000);
      finish_run();
      chk("t3_cycles_const", 64'(cycle_count), 16);

      // x0 writes are dropped.
      do_reset();
      cfg_write(0, 0, 32'h0000_0000);
      prog_clear();
      for (int k = 0; k < TO; k++) begin
         p_we[k] = 1'b1; p_rd[k] = 5'd0; p_data[k] = 32'hFFFF_FFFF;
      end
      launch(32'h20);
      finish_run();

      // Stall on the first beat, sparse entries 0, 2, 5.
      do_reset();
      cfg_write(0, 10, 32'hABCD_E000);
      cfg_write(2, 11, 32'h1111_1008);
      cfg_write(5, 12, 32'h0000_0056);
      prog_upper_imm();
      stall_cnt = 0;
      rdy_mode  = 2;
      launch(32'h20);
      finish_run();

      // Reset in the middle of CHECK.
      do_reset();
      cfg_write(0, 10, 32'hABCD_E000);
      cfg_write(1, 11, 32'h1111_1008);
      prog_upper_imm();
      rdy_mode = 3;
      launch(32'h20);
      chk("stalled_valid", 64'(res_valid), 1);
      reset = 1'b1;
      sb.delete();
      tick();
      chk("midrst_res_valid", 64'(res_valid), 0);
      chk("midrst_done", 64'(done), 0);
      reset = 1'b0;
      for (int i = 0; i < NC; i++) m_valid[i] = 1'b0;
      m_idle   = 1'b1;
      rdy_mode = 0;
      launch(32'h20);
      finish_run();

      // Randomised runs with random backpressure.
      for (int it = 0; it < 25; it++) begin
         do_reset();
         rdy_mode = 1;
         epc = 32'(4 * $urandom_range(0, 23));
         prog_random(epc);
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 2) != 0) begin
               rd = $urandom_range(0, 7);
               cfg_write(i, rd, ($urandom_range(0, 1) == 1) ? m_sh[rd] : $urandom);
            end
         end
         launch(epc);
         finish_run();
         if ($urandom_range(0, 1) == 1) begin
            cfg_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom);
            epc = 32'(4 * $urandom_range(0, 23));
            prog_random(epc);
            launch(epc);
            finish_run();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
